// File: rtl/generic_mem_pkg.sv
// Shared definitions for the memory utility blocks: loader state encoding
// and the bytes-per-word helper.
package generic_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } loader_state_t;

  // Number of byte lanes in a memory word.
  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/generic_mem_loader_byte_word_packer.sv
// Assembles a little-endian byte stream into words: tracks the current byte
// lane, inserts each accepted byte into it and flags the last lane of a word.
// word_next is the word as it will look once the presented byte is taken, so
// the parent can register a complete word on the same edge as the last byte.
module byte_word_packer
  import generic_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  accept,
  input  logic [7:0]            byte_data,
  output logic [DATA_WIDTH-1:0] word_next,
  output logic                  last
);

  localparam int BPW = bytes_per_word(DATA_WIDTH);
  localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] word;

  assign last = (idx == IW'(BPW - 1));

  // Lane insertion: byte 0 of a word lands in the least significant lane.
  always_comb begin
    word_next = word;
    for (int l = 0; l < BPW; l++) begin
      if (idx == IW'(l)) word_next[8*l +: 8] = byte_data;
    end
  end

  // Lane index and partial word; both restart on a new session.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx  <= '0;
      word <= '0;
    end else if (clear) begin
      idx  <= '0;
      word <= '0;
    end else if (accept) begin
      word <= word_next;
      idx  <= last ? '0 : idx + IW'(1);
    end
  end

endmodule

// File: rtl/generic_mem_loader.sv
// Runtime memory image loader: packs a byte stream into words and writes
// them to consecutive addresses starting at a base, for a given word count.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | waiting for i_start; stream not accepted
//   ST_COLLECT | accepting bytes until a full word is packed
//   ST_WRITE   | one-cycle memory write of the packed word
//   ST_DONE    | one-cycle o_done pulse, then back to idle
module generic_mem_loader
  import generic_mem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [ADDRESS_WIDTH-1:0] i_base_addr,
  input  logic [ADDRESS_WIDTH:0]   i_word_count,
  input  logic                     i_byte_valid,
  input  logic [7:0]               i_byte_data,
  output logic                     o_byte_ready,
  output logic                     o_mem_we,
  output logic [ADDRESS_WIDTH-1:0] o_mem_address,
  output logic [DATA_WIDTH-1:0]    o_mem_write_data,
  output logic                     o_busy,
  output logic                     o_done
);

  loader_state_t            state;
  logic [ADDRESS_WIDTH-1:0] base;
  logic [ADDRESS_WIDTH:0]   count;
  logic [ADDRESS_WIDTH:0]   word_idx;

  logic                     accept;
  logic                     clear;
  logic                     last;
  logic [DATA_WIDTH-1:0]    word_next;

  // o_byte_ready is a register, so acceptance never loops back through it.
  assign accept = o_byte_ready && i_byte_valid;
  assign clear  = (state == ST_IDLE) && i_start;

  byte_word_packer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_packer (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .clear    (clear),
    .accept   (accept),
    .byte_data(i_byte_data),
    .word_next(word_next),
    .last     (last)
  );

  // Session sequencing with all outputs registered alongside the state.
  // word_idx advances when the write is launched, so in ST_WRITE it already
  // holds the count of words written including the current one.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state            <= ST_IDLE;
      base             <= '0;
      count            <= '0;
      word_idx         <= '0;
      o_byte_ready     <= 1'b0;
      o_mem_we         <= 1'b0;
      o_mem_address    <= '0;
      o_mem_write_data <= '0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
    end else begin
      o_mem_we <= 1'b0;
      o_done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            base     <= i_base_addr;
            count    <= i_word_count;
            word_idx <= '0;
            o_busy   <= 1'b1;
            if (i_word_count == '0) begin
              state  <= ST_DONE;
              o_done <= 1'b1;
            end else begin
              state        <= ST_COLLECT;
              o_byte_ready <= 1'b1;
            end
          end
        end
        ST_COLLECT: begin
          if (accept && last) begin
            state            <= ST_WRITE;
            o_byte_ready     <= 1'b0;
            o_mem_we         <= 1'b1;
            o_mem_address    <= base + word_idx[ADDRESS_WIDTH-1:0];
            o_mem_write_data <= word_next;
            word_idx         <= word_idx + 1'b1;
          end
        end
        ST_WRITE: begin
          if (word_idx == count) begin
            state  <= ST_DONE;
            o_done <= 1'b1;
          end else begin
            state        <= ST_COLLECT;
            o_byte_ready <= 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state        <= ST_IDLE;
          o_byte_ready <= 1'b0;
          o_busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/generic_mem_loader.md
# generic_mem_loader

Writer-side counterpart to the synchronous-read memory primitives. Accepts a little-endian byte stream over a valid/ready handshake, packs DATA_WIDTH/8 bytes per word, and issues single-cycle word writes to sequential addresses of an attached memory write port. Used to program RAM/ROM-style images at runtime instead of via an init file. Each session starts at a base address and runs for a word count; completion is signalled with a done pulse.

## Interface
- ADDRESS_WIDTH, 10, word-address width of the target memory
- DATA_WIDTH, 32, memory word width; multiple of 8, ≥ 8 (BPW = DATA_WIDTH/8)

- i_clk  in  1  clock; all logic on posedge
- i_rst_n  in  1  reset, synchronous, active-low
- i_start  in  1  session start request, sampled in IDLE only
- i_base_addr  in  ADDRESS_WIDTH  first word address, latched on accepted start
- i_word_count  in  ADDRESS_WIDTH+1  words to write, latched on accepted start
- i_byte_valid  in  1  byte stream valid
- i_byte_data  in  8  byte stream data
- o_byte_ready  out  1  loader accepts a byte this cycle
- o_mem_we  out  1  memory write enable, one cycle per word
- o_mem_address  out  ADDRESS_WIDTH  memory write address
- o_mem_write_data  out  DATA_WIDTH  memory write data
- o_busy  out  1  session in progress (any state except IDLE)
- o_done  out  1  one-cycle pulse at session end

## Operation
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE: o_byte_ready=0. i_start=1 latches base, count; clears byte index and word index. Count 0 → DONE; else → COLLECT.
- COLLECT: o_byte_ready=1. On i_byte_valid&o_byte_ready, byte stored at lane [8*idx +: 8] (byte 0 = LSB), idx increments. Accepting byte with idx==BPW-1 → WRITE, idx cleared.
- WRITE: o_byte_ready=0; o_mem_we=1, o_mem_address=(base+word_idx) mod 2^ADDRESS_WIDTH, o_mem_write_data=packed word. word_idx increments. If new word_idx==count → DONE, else → COLLECT.
- DONE: o_done=1 for exactly one cycle, → IDLE.
- i_start outside IDLE ignored; bytes presented outside COLLECT not consumed.
- Address wraps modulo 2^ADDRESS_WIDTH; no error flag.
- o_mem_address/o_mem_write_data hold last values when o_mem_we=0; only valid with we.

## Timing
- All outputs registered or decoded from registered state; no combinational path from i_byte_valid to o_byte_ready.
- Reset: state IDLE; o_byte_ready, o_mem_we, o_busy, o_done = 0; o_mem_address, o_mem_write_data, indices = 0.
- Reset asserted mid-session: next edge returns to IDLE, partial word discarded, no write issued.
- Start accepted at edge k → o_busy=1 and o_byte_ready=1 from cycle k+1.
- Last byte of a word accepted at edge t → o_mem_we=1 in cycle t+1, o_byte_ready=0 in that cycle, ready again in t+2 if words remain.
- Peak throughput: BPW+1 cycles per word with i_byte_valid held high.
- Final write cycle is followed by o_done the next cycle, then o_busy=0 the cycle after.
- Write data is readable through a sync-read port two cycles after o_mem_we (write edge + read register).

## Structure
- Package generic_mem_pkg: loader state enum typedef; localparam helper for BPW; shared by future memory utilities.
- Sub-module byte_word_packer: byte index counter, lane insertion, last-byte flag; parameterized by DATA_WIDTH. FSM and address counter stay in the top.

## Test plan
- Reset values: hold i_rst_n=0 3 cycles → all outputs 0, o_byte_ready=0.
- Single word, DATA_WIDTH=32: base=0x010, count=1, bytes 0x78,0x56,0x34,0x12 back-to-back → one we with address 0x010, data 0x12345678; o_done one cycle later; total 1+4+1+1 cycles from start.
- Backpressure/gaps: count=3, random i_byte_valid gaps → exactly 3 writes to base..base+2, data matches stream; no byte lost or duplicated.
- Wrap and zero: ADDRESS_WIDTH=4, base=0xE, count=4 → writes to 0xE,0xF,0x0,0x1; separate start with count=0 → o_done next cycle, no we.
- Ignored start / mid-reset: i_start pulsed during COLLECT → no relatch; reset after 2 of 4 bytes → no write, IDLE; new session writes correct word.
- Readback: loader drives a sync-read memory model; after session, reading each address returns the written words.
